// File: rtl/dsp_ctrl_pkg.sv
// Shared definitions for the DSP program controller: FSM states, opcodes and
// the byte layout of the I2C register image.
package dsp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_WREQ   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [3:0] OP_NOP        = 4'd0;
    localparam logic [3:0] OP_SET_ADDR   = 4'd1;
    localparam logic [3:0] OP_WRITE_WORD = 4'd2;
    localparam logic [3:0] OP_RUN        = 4'd3;
    localparam logic [3:0] OP_HALT       = 4'd4;
    localparam logic [3:0] OP_SOFT_RESET = 4'd5;

    localparam int CMD_BYTE  = 0;
    localparam int REG1_BYTE = 1;
    localparam int REG2_BYTE = 2;
    localparam int REG3_BYTE = 3;
    localparam int REG4_BYTE = 4;

    function automatic logic [7:0] mem_byte(input logic [255:0] mem, input int idx);
        return mem[idx*8 +: 8];
    endfunction

endpackage

// File: rtl/dsp_prog_ctrl_if.sv
// Program-RAM write port between the controller (master) and the DSP core (slave).
interface dsp_prog_ctrl_if #(
    parameter int PROG_AW = 10
);
    logic [PROG_AW-1:0] prog_addr;
    logic [31:0]        prog_data;
    logic               prog_req;
    logic               prog_ack;

    modport master (output prog_addr, output prog_data, output prog_req, input prog_ack);
    modport slave  (input prog_addr, input prog_data, input prog_req, output prog_ack);
endinterface

// File: rtl/dsp_prog_timeout.sv
// Acknowledge-timeout counter; only compiled with DSP_PROG_ACK_TIMEOUT_EN.
// expire is high during the LIMIT-th consecutive enabled cycle after a clear.
`ifdef DSP_PROG_ACK_TIMEOUT_EN
module dsp_prog_timeout #(
    parameter int LIMIT = 255
) (
    input  logic mclk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expire = (cnt_q == CW'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule
`endif

// File: rtl/dsp_prog_ctrl.sv
// I2C-driven DSP program loader / run control. Optional macro
// DSP_PROG_ACK_TIMEOUT_EN bounds the wait for prog_ack to ACK_TIMEOUT cycles.
module dsp_prog_ctrl
    import dsp_ctrl_pkg::*;
#(
    parameter int PROG_AW     = 10,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                   mclk,
    input  logic                   reset_n,
    input  logic [255:0]           i2c_mem,
    dsp_prog_ctrl_if.master        prog,
    output logic                   core_run,
    output logic                   core_rst,
    output logic                   busy,
    output logic                   err,
    output logic [7:0]             cmd_count
);
    state_e             state_q, state_d;
    logic [7:0]         last_cmd_q, last_cmd_d;
    logic [3:0]         op_q, op_d;
    logic [31:0]        regs_q, regs_d;
    logic [PROG_AW-1:0] addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               req_q, req_d;
    logic               run_q, run_d;
    logic               rst_pulse_q, rst_pulse_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [7:0]         count_q, count_d;

    logic [7:0]   cmd_in;
    logic [31:0]  regs_in;
    logic [215:0] unused_i2c_bytes;
    logic         ack_expired;

    assign cmd_in  = mem_byte(i2c_mem, CMD_BYTE);
    assign regs_in = {mem_byte(i2c_mem, REG4_BYTE), mem_byte(i2c_mem, REG3_BYTE),
                      mem_byte(i2c_mem, REG2_BYTE), mem_byte(i2c_mem, REG1_BYTE)};
    assign unused_i2c_bytes = i2c_mem[255:40];

`ifdef DSP_PROG_ACK_TIMEOUT_EN
    dsp_prog_timeout #(
        .LIMIT(ACK_TIMEOUT)
    ) u_timeout (
        .mclk    (mclk),
        .reset_n (reset_n),
        .clr     (state_q != ST_WREQ),
        .en      (state_q == ST_WREQ),
        .expire  (ack_expired)
    );
`else
    assign ack_expired = 1'b0;
    // ACK_TIMEOUT has no effect here; referenced so both builds share one parameter list.
    if (ACK_TIMEOUT < 1) begin : g_ack_timeout_unused
    end
`endif

    always_comb begin
        state_d     = state_q;
        last_cmd_d  = last_cmd_q;
        op_d        = op_q;
        regs_d      = regs_q;
        addr_d      = addr_q;
        data_d      = data_q;
        req_d       = req_q;
        run_d       = run_q;
        rst_pulse_d = 1'b0;
        err_d       = err_q;
        count_d     = count_q;

        case (state_q)
            ST_IDLE: begin
                // Edits made while busy are picked up here with whatever reg bytes are current.
                if (cmd_in != last_cmd_q) begin
                    last_cmd_d = cmd_in;
                    op_d       = cmd_in[3:0];
                    regs_d     = regs_in;
                    state_d    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_DONE;
                case (op_q)
                    OP_NOP: ;
                    OP_SET_ADDR: addr_d = PROG_AW'(regs_q[15:0]);
                    OP_WRITE_WORD: begin
                        if (run_q) begin
                            err_d = 1'b1;
                        end else begin
                            data_d  = regs_q;
                            req_d   = 1'b1;
                            state_d = ST_WREQ;
                        end
                    end
                    OP_RUN:  run_d = 1'b1;
                    OP_HALT: run_d = 1'b0;
                    OP_SOFT_RESET: begin
                        rst_pulse_d = 1'b1;
                        run_d       = 1'b0;
                    end
                    default: err_d = 1'b1;
                endcase
            end
            ST_WREQ: begin
                if (prog.prog_ack) begin
                    req_d   = 1'b0;
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_DONE;
                end else if (ack_expired) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                count_d = count_q + 8'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            last_cmd_q  <= '0;
            op_q        <= '0;
            regs_q      <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            req_q       <= 1'b0;
            run_q       <= 1'b0;
            rst_pulse_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_cmd_q  <= last_cmd_d;
            op_q        <= op_d;
            regs_q      <= regs_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            req_q       <= req_d;
            run_q       <= run_d;
            rst_pulse_q <= rst_pulse_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            count_q     <= count_d;
        end
    end

    assign prog.prog_addr = addr_q;
    assign prog.prog_data = data_q;
    assign prog.prog_req  = req_q;
    assign core_run       = run_q;
    assign core_rst       = rst_pulse_q;
    assign busy           = busy_q;
    assign err            = err_q;
    assign cmd_count      = count_q;

endmodule

// File: tb/tb_dsp_prog_ctrl.sv
// Self-checking bench for dsp_prog_ctrl: directed cases plus randomized command
// stream against a transaction-level model of the command set.
module tb_dsp_prog_ctrl;
    localparam int PROG_AW     = 10;
    localparam int ACK_TIMEOUT = 255;

    logic         mclk = 1'b0;
    logic         reset_n;
    logic [255:0] i2c_mem;
    logic         core_run, core_rst, busy, err;
    logic [7:0]   cmd_count;

    dsp_prog_ctrl_if #(.PROG_AW(PROG_AW)) prog_if ();

    dsp_prog_ctrl #(
        .PROG_AW     (PROG_AW),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .mclk      (mclk),
        .reset_n   (reset_n),
        .i2c_mem   (i2c_mem),
        .prog      (prog_if),
        .core_run  (core_run),
        .core_rst  (core_rst),
        .busy      (busy),
        .err       (err),
        .cmd_count (cmd_count)
    );

    always #5 mclk = ~mclk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: architectural state as seen by the host.
    logic [PROG_AW-1:0] m_addr;
    logic [31:0]        m_data;
    logic               m_run, m_err;
    logic [7:0]         m_count, m_last;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = '0; m_data = '0; m_run = 1'b0; m_err = 1'b0; m_count = '0; m_last = '0;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_addr"},  32'(prog_if.prog_addr), 32'(m_addr));
        check_eq({tag, "_data"},  prog_if.prog_data, m_data);
        check_eq({tag, "_req"},   32'(prog_if.prog_req), 32'd0);
        check_eq({tag, "_run"},   32'(core_run), 32'(m_run));
        check_eq({tag, "_rst"},   32'(core_rst), 32'd0);
        check_eq({tag, "_err"},   32'(err), 32'(m_err));
        check_eq({tag, "_count"}, 32'(cmd_count), 32'(m_count));
        check_eq({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        i2c_mem = '0;
        prog_if.prog_ack = 1'b0;
        model_reset();
        repeat (3) @(negedge mclk);
        reset_n = 1'b1;
        repeat (4) @(negedge mclk);
        check_state("reset");
    endtask

    function automatic logic [7:0] fresh_cmd(input logic [3:0] op);
        logic [7:0] c;
        c = {1'($urandom_range(0, 1)), 3'b000, op};
        if (c == m_last) c[7] = ~c[7];
        return c;
    endfunction

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge mclk);
            n++;
        end
        check_eq("idle_bound", 32'(busy), 32'd0);
    endtask

    // One host transaction. ack_dly < 0 means the core never acknowledges.
    task automatic issue(input logic [7:0] cmd_in, input logic [31:0] regs, input int ack_dly);
        logic [7:0] cmd;
        logic [3:0] op;
        logic       wr, pulse;
        cmd = cmd_in;
        if (cmd == m_last) cmd[7] = ~cmd[7];
        op = cmd[3:0];
        i2c_mem[39:8] = regs;
        @(negedge mclk);
        i2c_mem[7:0] = cmd;
        m_last = cmd;
        wr    = (op == 4'd2) && !m_run;
        pulse = (op == 4'd5);
        case (op)
            4'd0: ;
            4'd1: m_addr = regs[PROG_AW-1:0];
            4'd2: if (m_run) m_err = 1'b1; else m_data = regs;
            4'd3: m_run = 1'b1;
            4'd4: m_run = 1'b0;
            4'd5: m_run = 1'b0;
            default: m_err = 1'b1;
        endcase
        @(negedge mclk);
        check_eq("busy_set", 32'(busy), 32'd1);
        if (!wr) prog_if.prog_ack = 1'($urandom_range(0, 1));
        @(negedge mclk);
        prog_if.prog_ack = 1'b0;
        check_eq("req_latency", 32'(prog_if.prog_req), 32'(wr));
        check_eq("run_latency", 32'(core_run), 32'(m_run));
        check_eq("rst_pulse", 32'(core_rst), 32'(pulse));
        if (wr) begin
            check_eq("wdata", prog_if.prog_data, regs);
            if (ack_dly >= 0) begin
                repeat (ack_dly) begin
                    @(negedge mclk);
                    check_eq("req_hold", 32'(prog_if.prog_req), 32'd1);
                    check_eq("data_hold", prog_if.prog_data, regs);
                end
                prog_if.prog_ack = 1'b1;
                @(negedge mclk);
                prog_if.prog_ack = 1'b0;
                check_eq("req_drop", 32'(prog_if.prog_req), 32'd0);
                m_addr = m_addr + 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
        wait_idle(ack_dly < 0 ? ACK_TIMEOUT + 20 : 20);
        m_count = m_count + 8'd1;
        check_state("done");
        $display("cmd=%02h regs=%08h addr=%03h run=%0d err=%0d count=%0d",
                 cmd, regs, prog_if.prog_addr, core_run, err, cmd_count);
    endtask

    initial begin
        logic [7:0]  wcmd, x1, x2;
        logic [31:0] wdata;

        apply_reset();

        // Basic address load, write with delayed ack, wraparound.
        issue(8'h01, 32'h0000_0010, 0);
        issue(8'h82, 32'hDEAD_BEEF, 3);
        issue(8'h01, 32'h0000_03FF, 0);
        issue(8'h82, $urandom, 2);

        // Write while running is refused; soft reset stops the core.
        issue(8'h03, $urandom, 0);
        issue(8'h82, $urandom, 0);
        issue(8'h05, $urandom, 0);

        apply_reset();
        issue(8'h0F, $urandom, 0);

        // Two command edits during a write: only the latest executes, with the latest regs.
        issue(fresh_cmd(4'd4), $urandom, 0);
        wcmd  = fresh_cmd(4'd2);
        wdata = 32'hCAFE_0001;
        x1    = {~wcmd[7], 7'h01};
        x2    = {wcmd[7], 7'h01};
        i2c_mem[39:8] = wdata;
        @(negedge mclk);
        i2c_mem[7:0] = wcmd;
        repeat (2) @(negedge mclk);
        check_eq("mid_req", 32'(prog_if.prog_req), 32'd1);
        i2c_mem[39:8] = 32'h0000_0111;
        i2c_mem[7:0]  = x1;
        @(negedge mclk);
        i2c_mem[39:8] = 32'h0000_0222;
        i2c_mem[7:0]  = x2;
        @(negedge mclk);
        check_eq("mid_data_hold", prog_if.prog_data, wdata);
        prog_if.prog_ack = 1'b1;
        @(negedge mclk);
        prog_if.prog_ack = 1'b0;
        m_data  = wdata;
        m_addr  = 10'h222;
        m_count = m_count + 8'd2;
        m_last  = x2;
        repeat (10) @(negedge mclk);
        check_state("mid_change");
        $display("cmd=%02h then %02h during write, addr=%03h count=%0d", x1, x2, prog_if.prog_addr, cmd_count);

        // Randomized command stream; long enough for cmd_count to wrap.
        for (int k = 0; k < 270; k++) begin
            int r;
            logic [3:0] op;
            r = $urandom_range(0, 99);
            if (r < 35)      op = 4'd2;
            else if (r < 50) op = 4'd4;
            else if (r < 65) op = 4'd1;
            else if (r < 93) op = 4'($urandom_range(0, 5));
            else             op = 4'($urandom_range(6, 15));
            issue(fresh_cmd(op), $urandom, $urandom_range(0, 4));
        end

        // Reset in the middle of a write request.
        issue(fresh_cmd(4'd4), $urandom, 0);
        i2c_mem[39:8] = $urandom;
        @(negedge mclk);
        i2c_mem[7:0] = fresh_cmd(4'd2);
        repeat (2) @(negedge mclk);
        check_eq("pre_rst_req", 32'(prog_if.prog_req), 32'd1);
        reset_n = 1'b0;
        i2c_mem = '0;
        #1;
        check_eq("async_rst_req", 32'(prog_if.prog_req), 32'd0);
        $display("reset asserted mid-write, prog_req=%0d", prog_if.prog_req);
        apply_reset();

`ifdef DSP_PROG_ACK_TIMEOUT_EN
        issue(fresh_cmd(4'd2), $urandom, -1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dsp_prog_ctrl.md
DSP_PROG_CTRL -- requirements
Module: dsp_prog_ctrl

Interface
REQ-001 Parameter PROG_AW, default 10, SHALL set the program-address width.
REQ-002 Parameter ACK_TIMEOUT, default 255, SHALL set the maximum wait for prog_ack in mclk cycles (used only under REQ-030).
REQ-003 mclk  input  1  SHALL be the single clock, shared with the I2C register stage.
REQ-004 reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 i2c_mem  input  256  SHALL be the I2C register image; byte0 = cmd, bytes1-4 = reg1-reg4, other bytes unused.
REQ-006 prog_addr  output  PROG_AW  SHALL be the DSP program-RAM word address.
REQ-007 prog_data  output  32  SHALL be the write word {reg4,reg3,reg2,reg1}.
REQ-008 prog_req  output  1  SHALL be the write request to the DSP core.
REQ-009 prog_ack  input  1  SHALL be the single-cycle write acknowledge from the DSP core.
REQ-010 core_run  output  1  SHALL be the DSP run enable (1 = running).
REQ-011 core_rst  output  1  SHALL be a one-cycle DSP soft-reset pulse.
REQ-012 busy  output  1  SHALL be high in every state except IDLE.
REQ-013 err  output  1  SHALL be a sticky error flag.
REQ-014 cmd_count  output  8  SHALL count executed commands, wrapping at 255->0.

Function
REQ-015 Trigger: in IDLE, cmd byte != last_cmd SHALL capture bytes0-4, update last_cmd and go to DECODE; the host writes reg1-4 before cmd.
REQ-016 cmd[7] is a host toggle bit; cmd[3:0] SHALL be the opcode: 0 NOP, 1 SET_ADDR, 2 WRITE_WORD, 3 RUN, 4 HALT, 5 SOFT_RESET.
REQ-017 States: IDLE, DECODE, WREQ, DONE; DONE SHALL return to IDLE after one cycle and increment cmd_count.
REQ-018 SET_ADDR: DECODE SHALL load prog_addr = {reg2,reg1}[PROG_AW-1:0] and go to DONE.
REQ-019 WRITE_WORD with core_run=0: DECODE->WREQ, prog_data driven and prog_req=1, held stable until prog_ack.
REQ-020 In WREQ, prog_ack=1 SHALL drop prog_req the next cycle, increment prog_addr modulo 2^PROG_AW and go to DONE.
REQ-021 WRITE_WORD with core_run=1 SHALL set err and issue no request, then go to DONE.
REQ-022 RUN and HALT SHALL set and clear core_run respectively in DECODE.
REQ-023 SOFT_RESET SHALL pulse core_rst for exactly one cycle, set core_run=0 and leave prog_addr unchanged.
REQ-024 Opcodes 6-15 SHALL set err and go to DONE; cmd_count still increments.
REQ-025 cmd changes while busy SHALL NOT be lost: they are compared against last_cmd on return to IDLE, and the then-current reg bytes are used.
REQ-026 prog_ack outside WREQ SHALL be ignored.
REQ-027 Latency: trigger to prog_req SHALL be 2 cycles; trigger to core_run change SHALL be 2 cycles.

Reset
REQ-028 Reset SHALL force IDLE, last_cmd=0, prog_addr=0, prog_data=0, prog_req=0, core_run=0, core_rst=0, err=0 and cmd_count=0, including during WREQ.
REQ-029 The reset value of cmd byte 0 SHALL NOT trigger a command.

Configuration
REQ-030 With DSP_PROG_ACK_TIMEOUT_EN defined, an unacknowledged WREQ SHALL end after ACK_TIMEOUT cycles: prog_req drops, err is set, prog_addr does not increment, and the FSM goes to DONE.
REQ-031 Without DSP_PROG_ACK_TIMEOUT_EN, WREQ SHALL wait indefinitely and no timeout counter is present.

Structure
REQ-032 Package dsp_ctrl_pkg SHALL hold the opcode constants, the state encoding and the cmd/reg byte offsets within i2c_mem.
REQ-033 One sub-module, dsp_prog_timeout (counter with clear and expire), SHALL be instantiated only under DSP_PROG_ACK_TIMEOUT_EN.

Verification
REQ-034 Stimulus: reg1-4=0x0010, then cmd=0x01. Required: prog_addr=0x010, cmd_count=1, no prog_req.
REQ-035 Stimulus: reg1-4=0xDEADBEEF, cmd=0x82, prog_ack 3 cycles after prog_req. Required: prog_data=0xDEADBEEF stable throughout, prog_addr 0x010->0x011.
REQ-036 Stimulus: prog_addr=0x3FF, then WRITE_WORD acked. Required: prog_addr wraps to 0x000.
REQ-037 Stimulus: cmd=0x03 (RUN), then cmd=0x82. Required: core_run=1, err=1, no prog_req; then cmd=0x05 gives core_rst pulse for 1 cycle and core_run=0.
REQ-038 Stimulus: cmd=0x0F. Required: err=1, cmd_count increments. Stimulus: cmd changed twice during WREQ. Required: exactly one further command executes, using the latest bytes.
REQ-039 Stimulus: reset_n low mid-WREQ. Required: prog_req=0 immediately; with the macro and no ack, err=1 after 255 cycles.
